// File: rtl/handwrite_pkg.sv
// Shared constants, state encoding, score type and helpers for handwrite_capture.
package handwrite_pkg;

  localparam int CANVAS_W   = 30;
  localparam int CANVAS_H   = 30;
  localparam int CANVAS_PIX = CANVAS_W * CANVAS_H;
  localparam int DIGIT_CNT  = 10;
  localparam int PIX_CNT_W  = 10;

  typedef logic [9:0] score_t;
  localparam score_t SCORE_MAX = 10'h3FF;

  typedef logic [PIX_CNT_W-1:0] pix_cnt_t;

  // State encoding kept as plain constants for compatibility with older tooling.
  typedef logic [2:0] state_t;
  localparam state_t S_DRAW  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_MATCH = 3'd2;
  localparam state_t S_EMIT  = 3'd3;
  localparam state_t S_CLEAR = 3'd4;

  function automatic logic [9:0] pix_idx(input int y, input int x);
    return 10'(y * CANVAS_W + x);
  endfunction

  function automatic score_t popcount_row(input logic [CANVAS_W-1:0] bits);
    score_t n;
    n = '0;
    for (int i = 0; i < CANVAS_W; i++) begin
      n = n + score_t'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/digit_template_rom.sv
// Combinational reference glyph ROM: ten 30x30 seven-segment style digits,
// bars three pixels thick, returned one row at a time (bit x = column x).
module digit_template_rom
  import handwrite_pkg::*;
(
  input  logic [3:0]          digit,
  input  logic [4:0]          row,
  output logic [CANVAS_W-1:0] tmpl_row
);

  // Horizontal bar spans columns 5..24; vertical bars cover columns 5..7 and 22..24.
  localparam logic [CANVAS_W-1:0] BarH = 30'h01FF_FFE0;
  localparam logic [CANVAS_W-1:0] BarL = 30'h0000_00E0;
  localparam logic [CANVAS_W-1:0] BarR = 30'h01C0_0000;

  localparam logic [4:0] TopLo = 5'd2;
  localparam logic [4:0] TopHi = 5'd4;
  localparam logic [4:0] MidLo = 5'd13;
  localparam logic [4:0] MidHi = 5'd15;
  localparam logic [4:0] BotLo = 5'd25;
  localparam logic [4:0] BotHi = 5'd27;

  logic [6:0] seg;  // {g, f, e, d, c, b, a}
  logic       in_top;
  logic       in_mid;
  logic       in_bot;
  logic       in_upper;
  logic       in_lower;

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b011_1111;
      4'd1:    seg = 7'b000_0110;
      4'd2:    seg = 7'b101_1011;
      4'd3:    seg = 7'b100_1111;
      4'd4:    seg = 7'b110_0110;
      4'd5:    seg = 7'b110_1101;
      4'd6:    seg = 7'b111_1101;
      4'd7:    seg = 7'b000_0111;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b110_1111;
      default: seg = 7'b000_0000;
    endcase
  end

  assign in_top   = (row >= TopLo) && (row <= TopHi);
  assign in_mid   = (row >= MidLo) && (row <= MidHi);
  assign in_bot   = (row >= BotLo) && (row <= BotHi);
  assign in_upper = (row >= TopLo) && (row <= MidHi);
  assign in_lower = (row >= MidLo) && (row <= BotHi);

  always_comb begin
    tmpl_row = '0;
    if ((seg[0] && in_top) || (seg[6] && in_mid) || (seg[3] && in_bot)) begin
      tmpl_row = tmpl_row | BarH;
    end
    if ((seg[5] && in_upper) || (seg[4] && in_lower)) begin
      tmpl_row = tmpl_row | BarL;
    end
    if ((seg[1] && in_upper) || (seg[2] && in_lower)) begin
      tmpl_row = tmpl_row | BarR;
    end
  end

endmodule

// File: rtl/handwrite_capture.sv
// Pen-stroke capture onto a 30x30 canvas with idle-timeout nearest-template digit
// classification. Define HANDWRITE_THICK_PEN_EN for a 3x3 brush instead of one pixel.
module handwrite_capture
  import handwrite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned MIN_PIXELS     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pen_valid,
  input  logic                  i_pen_down,
  input  logic [4:0]            i_pen_x,
  input  logic [4:0]            i_pen_y,
  input  logic                  i_clear,
  output logic [CANVAS_PIX-1:0] o_handwrite,
  output logic [3:0]            o_digit_answered,
  output logic                  o_digit_identified,
  output logic                  o_busy
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CANVAS_PIX-1:0] canvas_q, canvas_d;
  pix_cnt_t              pix_cnt_q, pix_cnt_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [3:0]            digit_q, digit_d;
  logic [4:0]            row_q, row_d;
  score_t                acc_q, acc_d;
  score_t                best_q, best_d;
  logic [3:0]            best_digit_q, best_digit_d;
  logic [3:0]            answer_q, answer_d;

  logic                  pen_hit;
  logic [CANVAS_PIX-1:0] paint_mask;
  logic [3:0]            new_pix;
  logic [PIX_CNT_W:0]    cnt_sum;
  pix_cnt_t              cnt_sat;

  logic [CANVAS_W-1:0]   tmpl_row;
  logic [CANVAS_W-1:0]   canvas_row;
  logic [9:0]            row_base;
  score_t                row_score;
  score_t                digit_total;
  logic                  new_best;

  assign pen_hit = i_pen_valid && i_pen_down &&
                   (i_pen_x < 5'(CANVAS_W)) && (i_pen_y < 5'(CANVAS_H));

  // Brush footprint and the number of pixels it newly sets.
  always_comb begin
    paint_mask = '0;
    new_pix    = '0;
    if (pen_hit) begin
`ifdef HANDWRITE_THICK_PEN_EN
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          int px;
          int py;
          px = int'(i_pen_x) + dx;
          py = int'(i_pen_y) + dy;
          if ((px >= 0) && (px < CANVAS_W) && (py >= 0) && (py < CANVAS_H)) begin
            paint_mask[pix_idx(py, px)] = 1'b1;
            if (!canvas_q[pix_idx(py, px)]) begin
              new_pix = new_pix + 4'd1;
            end
          end
        end
      end
`else
      paint_mask[pix_idx(int'(i_pen_y), int'(i_pen_x))] = 1'b1;
      new_pix = canvas_q[pix_idx(int'(i_pen_y), int'(i_pen_x))] ? 4'd0 : 4'd1;
`endif
    end
  end

  assign cnt_sum = {1'b0, pix_cnt_q} + {7'd0, new_pix};
  assign cnt_sat = (cnt_sum > 11'(CANVAS_PIX)) ? PIX_CNT_W'(CANVAS_PIX) : cnt_sum[PIX_CNT_W-1:0];

  digit_template_rom u_rom (
    .digit    (digit_q),
    .row      (row_q),
    .tmpl_row (tmpl_row)
  );

  assign row_base    = pix_idx(int'(row_q), 0);
  assign canvas_row  = canvas_q[row_base +: CANVAS_W];
  assign row_score   = popcount_row(canvas_row ^ tmpl_row);
  assign digit_total = acc_q + row_score;
  // Strict compare so a tie keeps the earlier (lower) digit.
  assign new_best    = (digit_total < best_q);

  always_comb begin
    state_d      = state_q;
    canvas_d     = canvas_q;
    pix_cnt_d    = pix_cnt_q;
    timer_d      = timer_q;
    digit_d      = digit_q;
    row_d        = row_q;
    acc_d        = acc_q;
    best_d       = best_q;
    best_digit_d = best_digit_q;
    answer_d     = answer_q;

    case (state_q)
      S_DRAW: begin
        if (pen_hit) begin
          canvas_d  = canvas_q | paint_mask;
          pix_cnt_d = cnt_sat;
        end else if (i_pen_valid && !i_pen_down && (pix_cnt_q != '0)) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (i_pen_valid && i_pen_down) begin
          canvas_d  = canvas_q | paint_mask;
          pix_cnt_d = cnt_sat;
          timer_d   = '0;
          state_d   = S_DRAW;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TimerLast) begin
            if (32'(pix_cnt_q) >= MIN_PIXELS) begin
              state_d      = S_MATCH;
              digit_d      = '0;
              row_d        = '0;
              acc_d        = '0;
              best_d       = SCORE_MAX;
              best_digit_d = '0;
            end else begin
              state_d = S_CLEAR;
            end
          end
        end
      end
      S_MATCH: begin
        if (row_q == 5'(CANVAS_H - 1)) begin
          acc_d = '0;
          row_d = '0;
          if (new_best) begin
            best_d       = digit_total;
            best_digit_d = digit_q;
          end
          if (digit_q == 4'(DIGIT_CNT - 1)) begin
            state_d  = S_EMIT;
            answer_d = new_best ? digit_q : best_digit_q;
          end else begin
            digit_d = digit_q + 4'd1;
          end
        end else begin
          acc_d = digit_total;
          row_d = row_q + 5'd1;
        end
      end
      S_EMIT: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        canvas_d  = '0;
        pix_cnt_d = '0;
        timer_d   = '0;
        best_d    = SCORE_MAX;
        state_d   = S_DRAW;
      end
      default: begin
        state_d = S_DRAW;
      end
    endcase

    // Abort wins over everything, including a same-cycle pen sample.
    if (i_clear) begin
      state_d      = S_DRAW;
      canvas_d     = '0;
      pix_cnt_d    = '0;
      timer_d      = '0;
      digit_d      = '0;
      row_d        = '0;
      acc_d        = '0;
      best_d       = SCORE_MAX;
      best_digit_d = '0;
      answer_d     = answer_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_DRAW;
      canvas_q     <= '0;
      pix_cnt_q    <= '0;
      timer_q      <= '0;
      digit_q      <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      best_q       <= SCORE_MAX;
      best_digit_q <= '0;
      answer_q     <= '0;
    end else begin
      state_q      <= state_d;
      canvas_q     <= canvas_d;
      pix_cnt_q    <= pix_cnt_d;
      timer_q      <= timer_d;
      digit_q      <= digit_d;
      row_q        <= row_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      best_digit_q <= best_digit_d;
      answer_q     <= answer_d;
    end
  end

  assign o_handwrite        = canvas_q;
  assign o_digit_answered   = answer_q;
  assign o_digit_identified = (state_q == S_EMIT);
  assign o_busy             = (state_q == S_MATCH) || (state_q == S_EMIT) ||
                              (state_q == S_CLEAR);

endmodule

// File: doc/handwrite_capture.md
# handwrite_capture

Producer side of the answer handshake that the scrolling problem display consumes. Captures pen strokes into a 30×30 canvas bitmap, driven continuously to the display as the handwriting overlay. After the pen has been idle for a timeout, it classifies the canvas by nearest-template matching against ten digit templates. It then issues a one-cycle identified pulse with the 4-bit digit and clears the canvas.

## Interface
- TIMEOUT_CYCLES, default 25_000_000: pen-idle cycles before classification (0.5 s at 50 MHz).
- MIN_PIXELS, default 8: minimum set pixels for a canvas to be classified.
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_pen_valid  in  1  pen sample strobe.
- i_pen_down  in  1  pen contact, qualified by i_pen_valid.
- i_pen_x  in  5  canvas column, 0..29.
- i_pen_y  in  5  canvas row, 0..29.
- i_clear  in  1  abort and wipe canvas.
- o_handwrite  out  900  canvas; bit y*30+x, 1 = ink.
- o_digit_answered  out  4  classified digit, 0..9.
- o_digit_identified  out  1  one-cycle pulse, answer valid.
- o_busy  out  1  high in S_MATCH/S_EMIT/S_CLEAR.

## Operation
- States: S_DRAW, S_WAIT, S_MATCH, S_EMIT, S_CLEAR.
- **S_DRAW**
  - A sample with valid & down & x<30 & y<30 sets the pixel and increments pix_cnt, saturating at 900.
    - Pixels that are already set do not increment the count.
    - Coordinates of 30 or more are ignored.
  - Valid & !down with pix_cnt>0 → S_WAIT, timer=0.
- **S_WAIT**
  - Timer increments each cycle.
  - A valid & down sample paints its pixel → S_DRAW.
  - On timer==TIMEOUT_CYCLES-1:
    - pix_cnt≥MIN_PIXELS → S_MATCH.
    - Otherwise → S_CLEAR with no pulse.
- **S_MATCH**
  - Iterates digit d=0..9 and row r=0..29, one row per cycle (300 cycles).
  - Row mismatch = popcount(canvas_row XOR template_row), accumulated into 10-bit score[d].
  - After row 29, score[d] is compared with best.
    - Strictly smaller replaces best/best_digit, so ties keep the lower digit.
  - Pen samples are ignored.
- **S_EMIT**
  - o_digit_answered=best_digit; o_digit_identified=1 for exactly this cycle → S_CLEAR.
- **S_CLEAR**
  - Canvas, pix_cnt, timer and best (0x3FF) are zeroed → S_DRAW.
- i_clear in any state: next cycle is S_DRAW with an empty canvas, counters cleared, no pulse. Matching is aborted.
- The interface has no backpressure. The consumer accepts only while idle, and a fresh stroke plus timeout always exceeds its scroll duration.

## Timing
- Reset values:
  - State S_DRAW.
  - o_handwrite=0, o_digit_answered=0, o_digit_identified=0, o_busy=0.
  - pix_cnt=0, timer=0.
- Pen write is visible on o_handwrite the cycle after the sample.
- Pulse timing: the S_WAIT cycle with timer==TIMEOUT_CYCLES-1 is cycle T. Then S_MATCH covers T+1..T+300, S_EMIT is T+301 (pulse), and S_CLEAR is T+302.
- o_handwrite is all-zero from T+303.
- o_digit_answered holds its value until the next S_EMIT; it is not cleared by S_CLEAR.
- A reset mid-match discards all state; no pulse.
- If i_clear and a pen sample arrive in the same cycle, i_clear wins.

## Configuration
- HANDWRITE_THICK_PEN_EN
  - Defined: a pen hit paints a 3×3 brush centred on (x,y), clipped at canvas edges. pix_cnt counts each newly set pixel.
  - Undefined: single-pixel pen.
- Classification and timing are identical in both builds.

## Structure
- handwrite_pkg holds:
  - CANVAS_W=30, CANVAS_H=30, DIGIT_CNT=10.
  - The state enum.
  - score_t (10-bit).
  - A pixel-index function (y*30+x).
- Sub-module digit_template_rom: combinational; inputs digit[3:0] and row[4:0]; output 30-bit template row. Holds the ten 30×30 reference glyphs.

## Test plan
Bench uses TIMEOUT_CYCLES=100, MIN_PIXELS=8.
- **Reset:** after i_rst, all outputs are 0 and o_busy=0.
- **Template self-match:** paint exactly template 7's pixels, then pen up.
  - Pulse on cycle T+301 with o_digit_answered=7.
  - Canvas 0 at T+303.
- **Undersized canvas:** paint 5 distinct pixels, then pen up → no pulse; canvas cleared 102 cycles after pen up.
- **Resume in S_WAIT:** pen down at timer=50 → timer restarts; the pulse is delayed by the full 100 cycles from the next pen-up.
- **i_clear during matching:** assert at T+150 → no pulse, o_busy=0 next cycle, canvas 0.
- **Out-of-range coordinates:** samples with x=30 or y=31 leave o_handwrite unchanged. With HANDWRITE_THICK_PEN_EN, a hit at (0,0) sets exactly 4 bits.
